// File: rtl/rle_enc_param_if.sv
// Stream bundle for the run-length encoder: symbol beats in, (symbol, count) tokens out.
// The master side drives symbols and out_rdy. The slave side is the encoder.
interface rle_enc_param_if #(
  parameter int SYMBOL_WIDTH = 2,
  parameter int COUNT_WIDTH  = 4
);
  logic [SYMBOL_WIDTH-1:0] in_data;
  logic                    in_vld;
  logic                    in_last;
  logic                    in_rdy;
  logic [SYMBOL_WIDTH-1:0] out_symbol;
  logic [COUNT_WIDTH-1:0]  out_count;
  logic                    out_last;
  logic                    out_vld;
  logic                    out_rdy;

  modport master (
    output in_data, in_vld, in_last, out_rdy,
    input  in_rdy, out_symbol, out_count, out_last, out_vld
  );

  modport slave (
    input  in_data, in_vld, in_last, out_rdy,
    output in_rdy, out_symbol, out_count, out_last, out_vld
  );
endinterface

// File: rtl/rle_enc_param.sv
// Parametrised run-length encoder with saturating counts and last-driven flush.
// The output token sits in a single register stage.
module rle_enc_param #(
  parameter int SYMBOL_WIDTH = 2,
  parameter int COUNT_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  rle_enc_param_if.slave bus
);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] ONE_CNT = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [SYMBOL_WIDTH-1:0] run_sym_r;
  logic [SYMBOL_WIDTH-1:0] run_sym_nxt_s;
  logic [COUNT_WIDTH-1:0]  run_cnt_r;
  logic [COUNT_WIDTH-1:0]  run_cnt_nxt_s;

  logic [SYMBOL_WIDTH-1:0] out_symbol_r;
  logic [COUNT_WIDTH-1:0]  out_count_r;
  logic                    out_last_r;
  logic                    out_vld_r;

  logic                    slot_free_s;
  logic                    in_rdy_s;
  logic                    accept_s;
  logic                    same_sym_s;
  logic                    emit_s;
  logic [SYMBOL_WIDTH-1:0] emit_sym_s;
  logic [COUNT_WIDTH-1:0]  emit_cnt_s;
  logic                    emit_last_s;

  // Handshake qualifiers shared by the FSM and the output stage.
  always_comb begin
    slot_free_s = !out_vld_r || bus.out_rdy;
    in_rdy_s    = !reset && (state_r != FLUSH) && slot_free_s;
    accept_s    = bus.in_vld && in_rdy_s;
    same_sym_s  = (bus.in_data == run_sym_r);
  end

  // Next state, next run register and token to emit.
  always_comb begin
    state_nxt_s   = state_r;
    run_sym_nxt_s = run_sym_r;
    run_cnt_nxt_s = run_cnt_r;
    emit_s        = 1'b0;
    emit_sym_s    = run_sym_r;
    emit_cnt_s    = run_cnt_r;
    emit_last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && bus.in_last) begin
          emit_s      = 1'b1;
          emit_sym_s  = bus.in_data;
          emit_cnt_s  = ONE_CNT;
          emit_last_s = 1'b1;
        end else if (accept_s) begin
          run_sym_nxt_s = bus.in_data;
          run_cnt_nxt_s = ONE_CNT;
          state_nxt_s   = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && same_sym_s && (run_cnt_r != MAX_CNT)) begin
          if (bus.in_last) begin
            emit_s        = 1'b1;
            emit_cnt_s    = run_cnt_r + ONE_CNT;
            emit_last_s   = 1'b1;
            run_sym_nxt_s = {SYMBOL_WIDTH{1'b0}};
            run_cnt_nxt_s = {COUNT_WIDTH{1'b0}};
            state_nxt_s   = IDLE;
          end else begin
            run_cnt_nxt_s = run_cnt_r + ONE_CNT;
          end
        end else if (accept_s) begin
          // Symbol change or saturation: close the held run, the beat opens a new one.
          emit_s        = 1'b1;
          run_sym_nxt_s = bus.in_data;
          run_cnt_nxt_s = ONE_CNT;
          state_nxt_s   = bus.in_last ? FLUSH : RUN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (slot_free_s) begin
          emit_s        = 1'b1;
          emit_cnt_s    = ONE_CNT;
          emit_last_s   = 1'b1;
          run_sym_nxt_s = {SYMBOL_WIDTH{1'b0}};
          run_cnt_nxt_s = {COUNT_WIDTH{1'b0}};
          state_nxt_s   = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        run_sym_nxt_s = {SYMBOL_WIDTH{1'b0}};
        run_cnt_nxt_s = {COUNT_WIDTH{1'b0}};
        state_nxt_s   = IDLE;
      end
    endcase
  end

  // State and run register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      run_sym_r <= {SYMBOL_WIDTH{1'b0}};
      run_cnt_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      run_sym_r <= run_sym_nxt_s;
      run_cnt_r <= run_cnt_nxt_s;
    end
  end

  // Output token register. An emit only happens when the slot is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_r    <= 1'b0;
      out_symbol_r <= {SYMBOL_WIDTH{1'b0}};
      out_count_r  <= {COUNT_WIDTH{1'b0}};
      out_last_r   <= 1'b0;
    end else if (emit_s) begin
      out_vld_r    <= 1'b1;
      out_symbol_r <= emit_sym_s;
      out_count_r  <= emit_cnt_s;
      out_last_r   <= emit_last_s;
    end else if (bus.out_rdy) begin
      out_vld_r <= 1'b0;
    end else begin
      out_vld_r <= out_vld_r;
    end
  end

  assign bus.in_rdy     = in_rdy_s;
  assign bus.out_vld    = out_vld_r;
  assign bus.out_symbol = out_symbol_r;
  assign bus.out_count  = out_count_r;
  assign bus.out_last   = out_last_r;
endmodule

// File: doc/rle_enc_param.md
# rle_enc_param

Parametrised run-length encoder and successor to the fixed 2-bit `rle1` encoder. It consumes a ready/valid stream of `SYMBOL_WIDTH`-bit symbols and emits (symbol, run-length) tokens, with saturating run counts and explicit end-of-stream flushing via `in_last`. It sits behind the wrapper's I/O demux/mux as one selectable design; with default parameters its output word is 6 bits, matching the existing bus slot.

## Interface
Parameters:
- `SYMBOL_WIDTH`, default 2: width of input symbols and `out_symbol`; must be at least 1.
- `COUNT_WIDTH`, default 4: width of `out_count`; must be at least 1. `MAX = 2^COUNT_WIDTH - 1`.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `in_data`  input  SYMBOL_WIDTH  input symbol.
- `in_vld`  input  1  input beat valid.
- `in_last`  input  1  beat is the final symbol of the stream; qualified by `in_vld`.
- `in_rdy`  output  1  encoder accepts a beat this cycle.
- `out_symbol`  output  SYMBOL_WIDTH  symbol of the emitted run.
- `out_count`  output  COUNT_WIDTH  run length, 1..MAX; 0 is never emitted.
- `out_last`  output  1  token closes the stream.
- `out_vld`  output  1  token valid.
- `out_rdy`  input  1  downstream accepts the token.

## Operation
- Accept means `in_vld && in_rdy`; transfer means `out_vld && out_rdy`.
- Internal state: run register (`run_sym`, `run_cnt`) plus FSM states IDLE (no run held), RUN (run held), FLUSH (a final single-symbol run is pending).
- Output stage is one register. "Slot free" = `!out_vld || out_rdy`.
- `in_rdy` = `!reset && state != FLUSH && slot free`. It is combinational from `out_rdy`, state, and `out_vld`.
- IDLE, accept, `in_last` = 0: load run = (`in_data`, 1) and go to RUN.
- IDLE, accept, `in_last` = 1: emit (`in_data`, 1, last = 1) and stay in IDLE.
- RUN, accept, same symbol, `run_cnt < MAX`, `in_last` = 0: increment `run_cnt`.
- RUN, accept, same symbol, `run_cnt < MAX`, `in_last` = 1: emit (`run_sym`, `run_cnt + 1`, last = 1) and go to IDLE.
- RUN, accept, same symbol, `run_cnt == MAX`: this is saturation.
  - Emit (`run_sym`, MAX, last = 0).
  - The new beat starts a fresh run with count 1.
  - If `in_last` = 1, go to FLUSH; otherwise stay in RUN.
- RUN, accept, different symbol: emit (`run_sym`, `run_cnt`, last = 0) and load run = (`in_data`, 1).
  - If `in_last` = 1, go to FLUSH; otherwise stay in RUN.
- FLUSH: when the slot is free, emit (`run_sym`, 1, last = 1) and go to IDLE. No beats are accepted in FLUSH.
- Runs never cross a `last` boundary. A new stream after IDLE starts fresh.
- RUN with no accept holds state indefinitely. A stream without `in_last` never flushes its final run.
- Arithmetic: `run_cnt` is COUNT_WIDTH bits and never wraps; saturation emits at MAX instead. For COUNT_WIDTH = 1, every beat emits a token of count 1.

## Timing
- Reset values, applied on the first rising edge with `reset` high:
  - `out_vld` = 0, `out_symbol` = 0, `out_count` = 0, `out_last` = 0.
  - State = IDLE, run register = 0.
  - `in_rdy` = 0 while `reset` is high, and 1 in the first cycle after reset is released.
- Reset asserted mid-stream discards the held run and any un-transferred output token. No partial token is emitted.
- Latency: a token appears on `out_*` in the cycle after the accept (or the FLUSH cycle) that produced it.
- The FLUSH token appears one cycle after the FLUSH emit. The end-of-stream with a differing last symbol therefore costs one extra cycle of `in_rdy` low.
- Output stability: while `out_vld && !out_rdy`, all `out_*` are held stable and `in_rdy` = 0.
- Simultaneous transfer and new emit in the same cycle: the register reloads, `out_vld` stays 1, and there is no bubble. Full throughput is one beat per cycle with `out_rdy` held high.
- A cycle with a transfer and no emit clears `out_vld`.

## Test plan
- Defaults, `out_rdy` = 1. Stream 1,1,1,2,2,3 with last on the 3. Expect tokens (1,3,0), (2,2,0), then (3,1,1). `in_rdy` drops for exactly one cycle in FLUSH.
- Saturation: COUNT_WIDTH = 4, 20 beats of symbol 2, last on the 20th. Expect (2,15,0) then (2,5,1).
- Saturation at the last beat: 16 beats of symbol 0, last on the 16th. Expect (0,15,0) then (0,1,1) via FLUSH.
- Backpressure: stream 0,1,0,1 with last on the final beat, and `out_rdy` low for 3 cycles after the first token appears. Expect the token held stable, `in_rdy` = 0 throughout, and the final sequence (0,1,0), (1,1,0), (0,1,0), (1,1,1) with no loss or duplication.
- Single-beat stream: symbol 3 with last. Expect (3,1,1) one cycle later and state back in IDLE. A following stream of 3,3 with last yields (3,2,1), with no merging across streams.
- Reset mid-run: feed 2,2,2, assert `reset` one cycle, then stream 1 with last. Expect only (1,1,1) and no stale count-3 token. `out_vld` is 0 during and right after reset.
